imm_extend_stage: RTL and testbench

Parameterised, registered immediate-generation stage for the pipelined ARM datapath, sitting between decode and the ALU/branch-target adders. Takes a raw 32-bit instruction word plus a format select, then extracts and zero- or sign-extends the immediate field (with scaling or halfword shift where the format needs it) to DATA_W bits. Output is registered behind a 2-entry skid buffer with valid/ready handshakes so decode stalls and flushes are absorbed without losing or duplicating immediates.

---
 rtl/imm_pkg.sv | 35 +++
 rtl/imm_extend_comb.sv | 56 +++++
 rtl/imm_extend_stage.sv | 108 ++++++++++
 tb/tb_imm_extend_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and field positions for the immediate-generation stage.
package imm_pkg;

   // Immediate format select carried alongside each instruction word.
   typedef enum logic [2:0] {
      ImmIZx  = 3'd0,
      ImmISx  = 3'd1,
      ImmD    = 3'd2,
      ImmCb   = 3'd3,
      ImmB    = 3'd4,
      ImmIw   = 3'd5,
      ImmRsv6 = 3'd6,
      ImmRsv7 = 3'd7
   } imm_mode_t;

   // Field positions within the 32-bit instruction word.
   localparam int unsigned I_MSB     = 21;
   localparam int unsigned I_LSB     = 10;
   localparam int unsigned D_MSB     = 20;
   localparam int unsigned D_LSB     = 12;
   localparam int unsigned CB_MSB    = 23;
   localparam int unsigned CB_LSB    = 5;
   localparam int unsigned B_MSB     = 25;
   localparam int unsigned B_LSB     = 0;
   localparam int unsigned IW_MSB    = 20;
   localparam int unsigned IW_LSB    = 5;
   localparam int unsigned IW_HW_LSB = 21;

   localparam int unsigned I_W  = I_MSB - I_LSB + 1;
   localparam int unsigned D_W  = D_MSB - D_LSB + 1;
   localparam int unsigned CB_W = CB_MSB - CB_LSB + 1;
   localparam int unsigned B_W  = B_MSB - B_LSB + 1;
   localparam int unsigned IW_W = IW_MSB - IW_LSB + 1;

endpackage

// File: rtl/imm_extend_comb.sv
// Combinational immediate extractor: instruction word + format -> extended immediate.
module imm_extend_comb
   import imm_pkg::*;
#(
   parameter int unsigned DATA_W      = 64,
   parameter bit          IW_SHIFT_EN = 1'b1
) (
   input  logic [31:0]       instr_i,
   input  imm_mode_t         mode_i,
   output logic [DATA_W-1:0] imm_o,
   output logic              err_o
);

   logic [I_W-1:0]    i_field;
   logic [D_W-1:0]    d_field;
   logic [CB_W-1:0]   cb_field;
   logic [B_W-1:0]    b_field;
   logic [IW_W-1:0]   iw_field;
   logic [1:0]        iw_hw;
   logic [5:0]        iw_shamt;
   logic [DATA_W-1:0] iw_zx;
   logic              unused_bits;

   assign i_field     = instr_i[I_MSB:I_LSB];
   assign d_field     = instr_i[D_MSB:D_LSB];
   assign cb_field    = instr_i[CB_MSB:CB_LSB];
   assign b_field     = instr_i[B_MSB:B_LSB];
   assign iw_field    = instr_i[IW_MSB:IW_LSB];
   assign iw_hw       = instr_i[IW_HW_LSB+1:IW_HW_LSB];
   assign iw_shamt    = {iw_hw, 4'b0000};
   assign iw_zx       = {{(DATA_W-IW_W){1'b0}}, iw_field};
   assign unused_bits = ^instr_i[31:26];

   // Decode format; scaling happens after extension so upper bits shift out cleanly.
   always_comb begin
      imm_o = '0;
      err_o = 1'b0;
      unique case (mode_i)
         ImmIZx: imm_o = {{(DATA_W-I_W){1'b0}}, i_field};
         ImmISx: imm_o = {{(DATA_W-I_W){i_field[I_W-1]}}, i_field};
         ImmD:   imm_o = {{(DATA_W-D_W){d_field[D_W-1]}}, d_field};
         ImmCb:  imm_o = {{(DATA_W-CB_W){cb_field[CB_W-1]}}, cb_field} << 2;
         ImmB:   imm_o = {{(DATA_W-B_W){b_field[B_W-1]}}, b_field} << 2;
         ImmIw: begin
            if (IW_SHIFT_EN) begin
               // Halfword positions beyond DATA_W shift out to zero.
               imm_o = iw_zx << iw_shamt;
            end else begin
               err_o = 1'b1;
            end
         end
         default: err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer on the output.
module imm_extend_stage
   import imm_pkg::*;
#(
   parameter int unsigned DATA_W      = 64,
   parameter bit          IW_SHIFT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [2:0]        mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] imm_out,
   output logic              err
);

   if (DATA_W < 32 || DATA_W > 128) begin : g_bad_data_w
      $error("imm_extend_stage: DATA_W must be within 32..128");
   end

   logic [DATA_W-1:0] new_imm;
   logic              new_err;

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_imm_q, main_imm_d;
   logic              main_err_q, main_err_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
   logic              skid_err_q, skid_err_d;

   logic              accept;
   logic              main_free;

   imm_extend_comb #(
      .DATA_W      (DATA_W),
      .IW_SHIFT_EN (IW_SHIFT_EN)
   ) u_extend (
      .instr_i (instr),
      .mode_i  (imm_mode_t'(mode)),
      .imm_o   (new_imm),
      .err_o   (new_err)
   );

   // Ready is purely the registered skid state, so out_ready never reaches in_ready.
   assign in_ready  = !skid_valid_q;
   assign accept    = in_valid && in_ready;
   assign main_free = !main_valid_q || out_ready;

   assign out_valid = main_valid_q;
   assign imm_out   = main_imm_q;
   assign err       = main_err_q;

   // Next-state for main and skid entries; flush overrides everything.
   always_comb begin
      main_valid_d = main_valid_q;
      main_imm_d   = main_imm_q;
      main_err_d   = main_err_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_err_d   = skid_err_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_free) begin
         if (skid_valid_q) begin
            // in_ready is low here, so no new word competes with the skid entry.
            main_valid_d = 1'b1;
            main_imm_d   = skid_imm_q;
            main_err_d   = skid_err_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_valid_d = 1'b1;
            main_imm_d   = new_imm;
            main_err_d   = new_err;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = new_imm;
         skid_err_d   = new_err;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_valid_q <= 1'b0;
         main_imm_q   <= '0;
         main_err_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_err_q   <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_imm_q   <= main_imm_d;
         main_err_q   <= main_err_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_err_q   <= skid_err_d;
      end
   end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: 64-bit, 32-bit and IW-disabled instances share stimulus.
module tb_imm_extend_stage;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] instr;
   logic [2:0]  mode;
   logic        out_ready;

   logic        in_ready, out_valid, err;
   logic [63:0] imm_out;
   logic        in_ready32, out_valid32, err32;
   logic [31:0] imm_out32;
   logic        in_ready_n, out_valid_n, err_n;
   logic [63:0] imm_out_n;

   int n_pass;
   int n_total;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  mode;
      logic [63:0] e64;
      logic [31:0] e32;
      logic        e_err;
   } vec_t;

   imm_extend_stage #(.DATA_W(64), .IW_SHIFT_EN(1'b1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imm_out   (imm_out),
      .err       (err)
   );

   imm_extend_stage #(.DATA_W(32), .IW_SHIFT_EN(1'b1)) dut32 (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready32),
      .instr     (instr),
      .mode      (mode),
      .out_valid (out_valid32),
      .out_ready (out_ready),
      .imm_out   (imm_out32),
      .err       (err32)
   );

   imm_extend_stage #(.DATA_W(64), .IW_SHIFT_EN(1'b0)) dut_noiw (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready_n),
      .instr     (instr),
      .mode      (mode),
      .out_valid (out_valid_n),
      .out_ready (out_ready),
      .imm_out   (imm_out_n),
      .err       (err_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] iw_word(input logic [1:0] hw, input logic [15:0] v);
      return {9'b0, hw, v, 5'b0};
   endfunction

   function automatic logic [31:0] izx_word(input logic [11:0] v);
      return {10'b0, v, 10'b0};
   endfunction

   // Present one input at the falling edge, then sample 1 unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
      n_total++; if (imm_out !== 64'h0) $display("FAIL reset_imm got %h want 0", imm_out); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
   endtask

   // Streams all vectors back to back with out_ready high: one result per cycle.
   task automatic test_modes();
      vec_t v[11];
      logic [63:0] e_n;
      logic        e_err_n;
      v[0]  = '{32'hFFEA_F000, 3'd0, 64'h0000_0000_0000_0ABC, 32'h0000_0ABC, 1'b0};
      v[1]  = '{32'hFFEA_F000, 3'd1, 64'hFFFF_FFFF_FFFF_FABC, 32'hFFFF_FABC, 1'b0};
      v[2]  = '{32'h0010_0000, 3'd2, 64'hFFFF_FFFF_FFFF_FF00, 32'hFFFF_FF00, 1'b0};
      v[3]  = '{32'h000F_F000, 3'd2, 64'h0000_0000_0000_00FF, 32'h0000_00FF, 1'b0};
      v[4]  = '{32'h00FF_FFE0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
      v[5]  = '{32'h0000_0001, 3'd4, 64'h0000_0000_0000_0004, 32'h0000_0004, 1'b0};
      v[6]  = '{32'h0200_0000, 3'd4, 64'hFFFF_FFFF_F800_0000, 32'hF800_0000, 1'b0};
      v[7]  = '{iw_word(2'd3, 16'h1234), 3'd5, 64'h1234_0000_0000_0000, 32'h0, 1'b0};
      v[8]  = '{iw_word(2'd1, 16'hBEEF), 3'd5, 64'h0000_0000_BEEF_0000, 32'hBEEF_0000, 1'b0};
      v[9]  = '{32'hFFFF_FFFF, 3'd6, 64'h0, 32'h0, 1'b1};
      v[10] = '{32'hFFFF_FFFF, 3'd7, 64'h0, 32'h0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         instr    = v[i].instr;
         mode     = v[i].mode;
         step();
         e_n     = (v[i].mode == 3'd5) ? 64'h0 : v[i].e64;
         e_err_n = (v[i].mode == 3'd5) ? 1'b1 : v[i].e_err;
         n_total++;
         if (out_valid !== 1'b1) $display("FAIL mode_valid[%0d] got %b want 1", i, out_valid);
         else n_pass++;
         n_total++;
         if (imm_out !== v[i].e64) $display("FAIL mode_imm64[%0d] got %h want %h", i, imm_out, v[i].e64);
         else n_pass++;
         n_total++;
         if (err !== v[i].e_err) $display("FAIL mode_err[%0d] got %b want %b", i, err, v[i].e_err);
         else n_pass++;
         n_total++;
         if (imm_out32 !== v[i].e32) $display("FAIL mode_imm32[%0d] got %h want %h", i, imm_out32, v[i].e32);
         else n_pass++;
         n_total++;
         if (imm_out_n !== e_n || err_n !== e_err_n)
            $display("FAIL mode_noiw[%0d] got %h/%b want %h/%b", i, imm_out_n, err_n, e_n, e_err_n);
         else n_pass++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      step();
      n_total++; if (out_valid !== 1'b0) $display("FAIL mode_drain got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      mode      = 3'd0;
      @(negedge clk); in_valid = 1'b1; instr = izx_word(12'h00A);
      step();
      n_total++; if (imm_out !== 64'hA || out_valid !== 1'b1) $display("FAIL bp_a_main got %h/%b want a/1", imm_out, out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got %b want 1", in_ready); else n_pass++;
      @(negedge clk); instr = izx_word(12'h00B);
      step();
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full got %b want 0", in_ready); else n_pass++;
      n_total++; if (imm_out !== 64'hA) $display("FAIL bp_a_hold got %h want a", imm_out); else n_pass++;
      @(negedge clk); instr = izx_word(12'h00C);
      step();
      n_total++; if (imm_out !== 64'hA || in_ready !== 1'b0) $display("FAIL bp_c_blocked got %h/%b want a/0", imm_out, in_ready); else n_pass++;
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      step();
      n_total++; if (imm_out !== 64'hB || out_valid !== 1'b1) $display("FAIL bp_b_out got %h/%b want b/1", imm_out, out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after got %b want 1", in_ready); else n_pass++;
      @(negedge clk); in_valid = 1'b1; instr = izx_word(12'h00C);
      step();
      n_total++; if (imm_out !== 64'hC || out_valid !== 1'b1) $display("FAIL bp_c_out got %h/%b want c/1", imm_out, out_valid); else n_pass++;
      @(negedge clk); in_valid = 1'b0;
      step();
      n_total++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_flush();
      // Both entries full, then flush with an input presented.
      out_ready = 1'b0;
      mode      = 3'd0;
      @(negedge clk); in_valid = 1'b1; instr = izx_word(12'h011);
      step();
      @(negedge clk); instr = izx_word(12'h022);
      step();
      @(negedge clk); flush = 1'b1; instr = izx_word(12'h033);
      step();
      n_total++; if (out_valid !== 1'b0) $display("FAIL flush_full_valid got %b want 0", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL flush_full_ready got %b want 1", in_ready); else n_pass++;
      // Main only full, so the flush-cycle input would be accepted without flush.
      @(negedge clk); flush = 1'b0; instr = izx_word(12'h044);
      step();
      @(negedge clk); flush = 1'b1; instr = izx_word(12'h055);
      step();
      n_total++; if (out_valid !== 1'b0) $display("FAIL flush_drop_valid got %b want 0", out_valid); else n_pass++;
      @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      n_total++; if (out_valid !== 1'b0) $display("FAIL flush_never_out got %b/%h want 0", out_valid, imm_out); else n_pass++;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      @(negedge clk); in_valid = 1'b1; mode = 3'd5; instr = iw_word(2'd0, 16'h5A5A);
      step();
      n_total++; if (imm_out !== 64'h5A5A || err_n !== 1'b1) $display("FAIL arst_pre got %h/%b want 5a5a/1", imm_out, err_n); else n_pass++;
      @(negedge clk); in_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      n_total++; if (out_valid !== 1'b0 || imm_out !== 64'h0) $display("FAIL arst_out got %b/%h want 0/0", out_valid, imm_out); else n_pass++;
      n_total++; if (err_n !== 1'b0 || out_valid_n !== 1'b0) $display("FAIL arst_err got %b/%b want 0/0", err_n, out_valid_n); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL arst_ready got %b want 1", in_ready); else n_pass++;
      @(negedge clk); reset_n = 1'b1;
      step();
      n_total++; if (out_valid !== 1'b0) $display("FAIL arst_release got %b want 0", out_valid); else n_pass++;
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      instr     = 32'h0;
      mode      = 3'd0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      step();
      test_reset();
      test_modes();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
